// File: rtl/debug_slave_scan_ctrl.sv
// debug_slave_scan_ctrl
// ---------------------
// System-clock-domain scan controller for the CPU debug slave. It follows
// already-synchronised virtual-JTAG state strobes (qualified by jtag_en),
// captures a per-instruction readback word, shifts the data register, and on
// update-DR issues one registered command to the debug core over a
// valid/ready handshake. If a new command arrives while an earlier one is
// still waiting for the consumer, the new one is dropped and a sticky
// overrun flag is set.
//
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   jtag_en             one-cycle strobe marking a TCK edge; qualifies vs_*, ir_in, tdi
//   vs_cdr/sdr/udr/uir  capture-DR, shift-DR, update-DR and update-IR strobes
//   ir_in               instruction value loaded on update-IR
//   tdi / tdo           serial data in / out (tdo = sr[0])
//   capture_data        NUM_CMD readback words, slice k at [k*DR_WIDTH +: DR_WIDTH]
//   act_valid/act_ready command handshake; act_cmd, act_take, jdo are the payload
//   busy                high while a scan is in progress (SHIFT state)
//   shift_count         bits shifted since the last capture, saturating at DR_WIDTH
//   overrun, clr_overrun sticky dropped-update flag and its clear
module debug_slave_scan_ctrl #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int TAKE_BIT = 35,
  parameter int CNT_W    = 6,
  localparam int NUM_CMD = 2**IR_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        jtag_en,
  input  logic                        vs_cdr,
  input  logic                        vs_sdr,
  input  logic                        vs_udr,
  input  logic                        vs_uir,
  input  logic [IR_WIDTH-1:0]         ir_in,
  input  logic                        tdi,
  input  logic [NUM_CMD*DR_WIDTH-1:0] capture_data,
  input  logic                        act_ready,
  input  logic                        clr_overrun,
  output logic                        tdo,
  output logic [DR_WIDTH-1:0]         jdo,
  output logic                        act_valid,
  output logic [IR_WIDTH-1:0]         act_cmd,
  output logic                        act_take,
  output logic                        busy,
  output logic [CNT_W-1:0]            shift_count,
  output logic                        overrun
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e                state_q, state_d;
  logic [DR_WIDTH-1:0]   sr_q, sr_d;
  logic [DR_WIDTH-1:0]   jdo_q, jdo_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [IR_WIDTH-1:0]   act_cmd_q, act_cmd_d;
  logic                  act_take_q, act_take_d;
  logic                  act_valid_q, act_valid_d;
  logic                  overrun_q, overrun_d;
  logic [CNT_W-1:0]      shift_count_q, shift_count_d;

  logic [DR_WIDTH-1:0]   cap_slice [NUM_CMD];

  for (genvar k = 0; k < NUM_CMD; k++) begin : g_slice
    assign cap_slice[k] = capture_data[k*DR_WIDTH +: DR_WIDTH];
  end

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    jdo_d         = jdo_q;
    ir_d          = ir_q;
    act_cmd_d     = act_cmd_q;
    act_take_d    = act_take_q;
    act_valid_d   = act_valid_q;
    overrun_d     = overrun_q;
    shift_count_d = shift_count_q;

    // The handshake runs every cycle, independent of jtag_en.
    if (act_valid_q && act_ready) begin
      act_valid_d = 1'b0;
    end

    // Clear is applied first so that a same-cycle overrun set wins.
    if (clr_overrun) begin
      overrun_d = 1'b0;
    end

    // Only the highest-priority strobe acts: uir > cdr > udr > sdr.
    if (jtag_en) begin
      if (vs_uir) begin
        ir_d    = ir_in;
        state_d = ST_IDLE;
      end else if (vs_cdr) begin
        sr_d          = cap_slice[ir_q];
        shift_count_d = '0;
        state_d       = ST_SHIFT;
      end else if (vs_udr) begin
        if (state_q == ST_SHIFT) begin
          state_d = ST_IDLE;
          if (shift_count_q != '0) begin
            // A pending command that is not being taken this cycle blocks
            // the new one; otherwise the slot is free (or freeing now).
            if (act_valid_q && !act_ready) begin
              overrun_d = 1'b1;
            end else begin
              jdo_d       = sr_q;
              act_cmd_d   = ir_q;
              act_take_d  = (shift_count_q == CNT_W'(DR_WIDTH)) && sr_q[TAKE_BIT];
              act_valid_d = 1'b1;
            end
          end
        end
      end else if (vs_sdr) begin
        if (state_q == ST_SHIFT) begin
          sr_d = {tdi, sr_q[DR_WIDTH-1:1]};
          if (shift_count_q != CNT_W'(DR_WIDTH)) begin
            shift_count_d = shift_count_q + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      sr_q          <= '0;
      jdo_q         <= '0;
      ir_q          <= '0;
      act_cmd_q     <= '0;
      act_take_q    <= 1'b0;
      act_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      shift_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      jdo_q         <= jdo_d;
      ir_q          <= ir_d;
      act_cmd_q     <= act_cmd_d;
      act_take_q    <= act_take_d;
      act_valid_q   <= act_valid_d;
      overrun_q     <= overrun_d;
      shift_count_q <= shift_count_d;
    end
  end

  assign tdo         = sr_q[0];
  assign busy        = (state_q == ST_SHIFT);
  assign jdo         = jdo_q;
  assign act_valid   = act_valid_q;
  assign act_cmd     = act_cmd_q;
  assign act_take    = act_take_q;
  assign shift_count = shift_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_debug_slave_scan_ctrl.sv
// tb_debug_slave_scan_ctrl
// ------------------------
// Self-checking bench for debug_slave_scan_ctrl. Stimulus is driven one
// cycle at a time just after each rising edge; a behavioural model advances
// on the same cycle boundaries and pushes every command it expects the DUT
// to issue into a scoreboard queue. A monitor on the falling edge pops and
// compares a command whenever the DUT completes a valid/ready transfer, and
// also compares the visible scan state against the model.
module tb_debug_slave_scan_ctrl;

  localparam int IRW = 2;
  localparam int DRW = 38;
  localparam int TB  = 35;
  localparam int CW  = 6;
  localparam int NC  = 4;

  typedef struct {
    logic             rst_n;
    logic             en;
    logic             cdr;
    logic             sdr;
    logic             udr;
    logic             uir;
    logic [IRW-1:0]   ir;
    logic             tdi;
    logic             rdy;
    logic             clr;
    logic [NC*DRW-1:0] cap;
  } stim_t;

  typedef struct {
    logic [DRW-1:0] jdo;
    logic [IRW-1:0] cmd;
    logic           take;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t cur;
  logic              tdo, act_valid, act_take, busy, overrun;
  logic [DRW-1:0]    jdo;
  logic [IRW-1:0]    act_cmd;
  logic [CW-1:0]     shift_count;

  debug_slave_scan_ctrl #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TAKE_BIT(TB), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(cur.rst_n), .jtag_en(cur.en),
    .vs_cdr(cur.cdr), .vs_sdr(cur.sdr), .vs_udr(cur.udr), .vs_uir(cur.uir),
    .ir_in(cur.ir), .tdi(cur.tdi), .capture_data(cur.cap),
    .act_ready(cur.rdy), .clr_overrun(cur.clr),
    .tdo(tdo), .jdo(jdo), .act_valid(act_valid), .act_cmd(act_cmd),
    .act_take(act_take), .busy(busy), .shift_count(shift_count), .overrun(overrun)
  );

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  // Reference model state: what the DUT should show after the latest edge.
  logic [DRW-1:0] m_sr, m_jdo;
  logic [IRW-1:0] m_ir, m_cmd;
  logic           m_take, m_valid, m_ovr, m_shift;
  int             m_cnt;
  exp_t           sb[$];

  logic            rdy_cfg = 1'b1;
  logic [NC*DRW-1:0] cap_cfg;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic modelStep(input stim_t s);
    logic nvalid;
    exp_t e;
    if (!s.rst_n) begin
      m_sr = '0; m_jdo = '0; m_ir = '0; m_cmd = '0;
      m_take = 0; m_valid = 0; m_ovr = 0; m_shift = 0; m_cnt = 0;
      sb.delete();
      return;
    end
    nvalid = m_valid && !s.rdy;
    if (s.clr) m_ovr = 0;
    if (s.en) begin
      if (s.uir) begin
        m_ir = s.ir;
        m_shift = 0;
      end else if (s.cdr) begin
        m_sr = s.cap[int'(m_ir)*DRW +: DRW];
        m_cnt = 0;
        m_shift = 1;
      end else if (s.udr) begin
        if (m_shift) begin
          m_shift = 0;
          if (m_cnt > 0) begin
            if (m_valid && !s.rdy) begin
              m_ovr = 1;
            end else begin
              m_jdo  = m_sr;
              m_cmd  = m_ir;
              m_take = (m_cnt == DRW) && m_sr[TB];
              nvalid = 1;
              e.jdo = m_jdo; e.cmd = m_cmd; e.take = m_take;
              sb.push_back(e);
            end
          end
        end
      end else if (s.sdr && m_shift) begin
        m_sr = (m_sr >> 1) | ({{(DRW-1){1'b0}}, s.tdi} << (DRW-1));
        if (m_cnt < DRW) m_cnt++;
      end
    end
    m_valid = nvalid;
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    modelStep(cur);
    cur = s;
  endtask

  function automatic stim_t base();
    stim_t s;
    s.rst_n = 1; s.en = 0; s.cdr = 0; s.sdr = 0; s.udr = 0; s.uir = 0;
    s.ir = '0; s.tdi = 0; s.rdy = rdy_cfg; s.clr = 0; s.cap = cap_cfg;
    return s;
  endfunction

  task automatic jt(input logic cdr, sdr, udr, uir, input logic [IRW-1:0] ir, input logic tdi);
    stim_t s;
    s = base();
    s.en = 1; s.cdr = cdr; s.sdr = sdr; s.udr = udr; s.uir = uir; s.ir = ir; s.tdi = tdi;
    applyStimulus(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(base());
  endtask

  task automatic shiftWord(input logic [DRW-1:0] w, input int n);
    for (int i = 0; i < n; i++) jt(0, 1, 0, 0, '0, w[i]);
  endtask

  // Monitor: scoreboard pop on each completed transfer plus state compare.
  always @(negedge clk) begin
    if (checking) begin
      exp_t e;
      checkOutput("tdo", 64'(tdo), 64'(m_sr[0]));
      checkOutput("busy", 64'(busy), 64'(m_shift));
      checkOutput("shift_count", 64'(shift_count), 64'(m_cnt));
      checkOutput("overrun", 64'(overrun), 64'(m_ovr));
      checkOutput("act_valid", 64'(act_valid), 64'(m_valid));
      if (act_valid === 1'b1 && cur.rdy === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_cmd", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          checkOutput("sb_jdo", 64'(jdo), 64'(e.jdo));
          checkOutput("sb_cmd", 64'(act_cmd), 64'(e.cmd));
          checkOutput("sb_take", 64'(act_take), 64'(e.take));
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic [DRW-1:0] w;
    logic [DRW-1:0] pat;
    cap_cfg = {38'h1111111111, 38'h3F00000001, 38'h0, 38'h2222222222};
    cur = base();
    cur.rst_n = 0;
    s = base(); s.rst_n = 0;
    applyStimulus(s);
    checking = 1;
    applyStimulus(s);
    idle(1);
    checkOutput("reset_valid", 64'(act_valid), 64'(0));
    checkOutput("reset_jdo", 64'(jdo), 64'(0));

    $display("[TB] reset during shift");
    jt(1, 0, 0, 0, '0, 0);
    shiftWord(38'h3FFFFFFFFF, 10);
    s = base(); s.rst_n = 0;
    applyStimulus(s);
    jt(0, 0, 1, 0, '0, 0);
    idle(2);
    checkOutput("tp1_busy", 64'(busy), 64'(0));
    checkOutput("tp1_valid", 64'(act_valid), 64'(0));

    $display("[TB] full scan, take action");
    pat = 38'h2A5A5A5A5A;
    jt(0, 0, 0, 1, 2'd1, 0);
    jt(1, 0, 0, 0, '0, 0);
    shiftWord(pat, DRW);
    jt(0, 0, 1, 0, '0, 0);
    idle(1);
    checkOutput("tp2_jdo", 64'(jdo), 64'(pat));
    checkOutput("tp2_cmd", 64'(act_cmd), 64'(1));
    checkOutput("tp2_take", 64'(act_take), 64'(1));
    checkOutput("tp2_valid", 64'(act_valid), 64'(1));
    idle(1);
    checkOutput("tp2_valid_drop", 64'(act_valid), 64'(0));

    $display("[TB] capture-only then short scan");
    jt(0, 0, 0, 1, 2'd2, 0);
    jt(1, 0, 0, 0, '0, 0);
    idle(1);
    checkOutput("tp3_tdo", 64'(tdo), 64'(1));
    jt(0, 0, 1, 0, '0, 0);
    idle(1);
    checkOutput("tp3_nocmd", 64'(act_valid), 64'(0));
    jt(1, 0, 0, 0, '0, 0);
    shiftWord('0, 5);
    jt(0, 0, 1, 0, '0, 0);
    idle(1);
    checkOutput("tp3_take", 64'(act_take), 64'(0));
    checkOutput("tp3_cnt", 64'(shift_count), 64'(5));

    $display("[TB] overrun");
    rdy_cfg = 0;
    jt(1, 0, 0, 0, '0, 0);
    shiftWord(38'h0123456789, DRW);
    jt(0, 0, 1, 0, '0, 0);
    jt(1, 0, 0, 0, '0, 0);
    shiftWord(38'h3FEDCBA987, DRW);
    jt(0, 0, 1, 0, '0, 0);
    idle(1);
    checkOutput("tp4_ovr", 64'(overrun), 64'(1));
    checkOutput("tp4_jdo", 64'(jdo), 64'(38'h0123456789));
    jt(1, 0, 0, 0, '0, 0);
    shiftWord(38'h155555555, DRW);
    s = base(); s.en = 1; s.udr = 1; s.clr = 1;
    applyStimulus(s);
    idle(1);
    checkOutput("tp4_set_wins", 64'(overrun), 64'(1));
    s = base(); s.clr = 1;
    applyStimulus(s);
    idle(1);
    checkOutput("tp4_cleared", 64'(overrun), 64'(0));

    $display("[TB] accept while draining");
    jt(1, 0, 0, 0, '0, 0);
    shiftWord(38'h0F0F0F0F0F, DRW);
    rdy_cfg = 1;
    jt(0, 0, 1, 0, '0, 0);
    idle(1);
    checkOutput("tp5_valid", 64'(act_valid), 64'(1));
    checkOutput("tp5_jdo", 64'(jdo), 64'(38'h0F0F0F0F0F));
    checkOutput("tp5_ovr", 64'(overrun), 64'(0));
    idle(2);

    $display("[TB] uir aborts shift");
    jt(1, 0, 0, 0, '0, 0);
    shiftWord(38'h3, 4);
    jt(0, 0, 1, 1, 2'd3, 0);
    idle(1);
    checkOutput("tp6_busy", 64'(busy), 64'(0));
    checkOutput("tp6_valid", 64'(act_valid), 64'(0));
    jt(1, 0, 0, 0, '0, 0);
    idle(1);
    checkOutput("tp6_ir3_tdo", 64'(tdo), 64'(cap_cfg[3*DRW]));

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        w = DRW'({$urandom, $urandom});
        cap_cfg = {w, ~w, DRW'({$urandom, $urandom}), DRW'({$urandom, $urandom})};
      end
      s = base();
      s.rst_n = ($urandom_range(0, 499) != 0);
      s.en  = ($urandom_range(0, 9) < 7);
      s.cdr = ($urandom_range(0, 99) < 3);
      s.udr = ($urandom_range(0, 99) < 4);
      s.uir = ($urandom_range(0, 99) < 2);
      s.sdr = ($urandom_range(0, 99) < 85);
      s.ir  = IRW'($urandom);
      s.tdi = 1'($urandom);
      s.rdy = ($urandom_range(0, 9) < 6);
      s.clr = ($urandom_range(0, 99) < 5);
      applyStimulus(s);
    end

    rdy_cfg = 1;
    idle(4);
    checkOutput("sb_drained", 64'(sb.size()), 64'(0));
    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_slave_scan_ctrl.md
Name: debug_slave_scan_ctrl

Overview:
- Parametrised successor of the CPU debug-slave scan logic.
- Runs in the system clock domain, driven by already-synchronised virtual-JTAG state strobes.
- Captures per-instruction readback data, shifts the data register, and on update issues one registered command toward the debug core (break/ocimem/trace units) over a valid/ready handshake.
- Generalises IR width, DR width, command count and take/no-action selection, and adds backpressure with overrun detection.

Parameters:
- IR_WIDTH, 2, instruction register width; NUM_CMD = 2**IR_WIDTH.
- DR_WIDTH, 38, data register (jdo) width.
- TAKE_BIT, 35, sr bit selecting take_action (1) vs take_no_action (0); must be < DR_WIDTH.
- CNT_W, 6, shift counter width; must satisfy 2**CNT_W > DR_WIDTH.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, reset; one clock; reset is synchronous and active-low.
- jtag_en, input, 1, one-cycle strobe marking a TCK edge; all vs_* inputs, ir_in and tdi are sampled only when jtag_en=1.
- vs_cdr, input, 1, capture-DR.
- vs_sdr, input, 1, shift-DR.
- vs_udr, input, 1, update-DR.
- vs_uir, input, 1, update-IR.
- ir_in, input, IR_WIDTH, instruction value.
- tdi, input, 1, serial data in.
- capture_data, input, NUM_CMD*DR_WIDTH, readback word per command; slice k = bits [k*DR_WIDTH +: DR_WIDTH].
- act_ready, input, 1, consumer accepts the command.
- clr_overrun, input, 1, clears overrun.
- tdo, output, 1, serial data out = sr[0].
- jdo, output, DR_WIDTH, last accepted data word.
- act_valid, output, 1, command pending.
- act_cmd, output, IR_WIDTH, IR code of the pending command.
- act_take, output, 1, 1 = take_action, 0 = take_no_action.
- busy, output, 1, FSM in SHIFT.
- shift_count, output, CNT_W, bits shifted since last capture (saturating).
- overrun, output, 1, sticky: an update was dropped.

Behaviour:
- Reset (reset_n=0 at clk edge): sr, jdo, ir_q, act_cmd, act_take, act_valid, overrun and shift_count all 0; FSM=IDLE; tdo=0; busy=0.
- Event priority within one jtag_en cycle: uir > cdr > udr > sdr. Only the highest-priority event acts.
- uir: ir_q <= ir_in. If FSM=SHIFT, abort to IDLE with no command.
- cdr (any state): sr <= capture_data slice[ir_q]; shift_count <= 0; FSM <= SHIFT.
- sdr in SHIFT: sr <= {tdi, sr[DR_WIDTH-1:1]}; shift_count increments, saturating at DR_WIDTH. sdr in IDLE is ignored.
- udr in SHIFT: FSM <= IDLE. Then:
  - shift_count=0: no command (capture-update only).
  - Else if act_valid=1 and act_ready=0: command dropped; overrun <= 1; jdo, act_* unchanged.
  - Else accepted: jdo <= sr; act_cmd <= ir_q; act_take <= (shift_count==DR_WIDTH) & sr[TAKE_BIT]. A short scan always gives act_take=0. act_valid <= 1.
- udr in IDLE: ignored.
- Handshake: act_valid stays asserted until a cycle with act_valid=1 and act_ready=1, then clears next edge. If an update is accepted in that same cycle, act_valid stays 1 and carries the new command. act_cmd, act_take and jdo are stable while act_valid=1.
- Latency: accepted udr strobe at edge N gives act_valid=1 and jdo updated after edge N (visible cycle N+1).
- overrun clears on clr_overrun. If set and clear coincide, set wins.
- jtag_en=0: scan state frozen; handshake still operates.
- All outputs are registered except tdo (sr[0]) and busy (decode of FSM).

Test Plan:
- Reset mid-SHIFT after 10 sdr strobes -> all outputs 0, FSM IDLE, a following udr produces no act_valid.
- ir=2'b01, capture slice1=38'h0; shift 38 bits with bit 35=1, data 38'h2A_5A5A_5A5A; udr with act_ready=1 -> one cycle later jdo=38'h2A_5A5A_5A5A, act_cmd=1, act_take=1, act_valid=1 for exactly 1 cycle.
- Capture slice2=38'h3F_0000_0001; no shift; tdo=1; udr -> act_valid stays 0; then 5-bit shift -> tdo sequence 1,0,0,0,0; udr -> act_take=0, shift_count=5.
- act_ready=0 holding a command, second full scan and udr -> overrun=1, jdo/act_cmd unchanged. Same sequence with clr_overrun on the overrun cycle -> overrun=1. Next clr_overrun -> 0.
- act_ready=1 on the same cycle as a new udr -> act_valid remains 1 with new jdo, no overrun.
- uir (ir=3) asserted together with udr during SHIFT -> ir_q=3, FSM IDLE, no command.
